// File: rtl/lut_layer_pkg.sv
// Shared types and helpers for the neuron-serial LogicNets layer scheduler.
package lut_layer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Index width for a table of n entries; a single entry still needs one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Fan-in 0 occupies the most significant slice of the packed LUT address.
    function automatic int addr_lsb(input int k, input int fan_in, input int in_bits);
        return in_bits * (fan_in - 1 - k);
    endfunction

endpackage

// File: rtl/lut_tag_pipe.sv
// Fixed-latency tag delay line: carries {valid, neuron index} alongside the LUT read.
module lut_tag_pipe
    import lut_layer_pkg::*;
#(
    parameter int LUT_LAT = 1,
    parameter int NW      = 7
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_vld,
    input  logic [NW-1:0] i_idx,
    output logic          o_vld,
    output logic [NW-1:0] o_idx
);

    logic [NW:0] r_tag [LUT_LAT];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < LUT_LAT; i++) begin
                r_tag[i] <= '0;
            end
        end else begin
            r_tag[0] <= {i_vld, i_idx};
            for (int i = 1; i < LUT_LAT; i++) begin
                r_tag[i] <= r_tag[i-1];
            end
        end
    end

    assign o_vld = r_tag[LUT_LAT-1][NW];
    assign o_idx = r_tag[LUT_LAT-1][NW-1:0];

endmodule

// File: rtl/lut_layer_scheduler.sv
// Time-multiplexes one LUT evaluation port across all neurons of a LogicNets layer.
module lut_layer_scheduler
    import lut_layer_pkg::*;
#(
    parameter int N_IN      = 64,
    parameter int IN_BITS   = 2,
    parameter int FAN_IN    = 4,
    parameter int N_NEURONS = 128,
    parameter int OUT_BITS  = 2,
    parameter int LUT_LAT   = 1,
    localparam int IW = idx_w(N_IN),
    localparam int NW = idx_w(N_NEURONS)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [N_IN*IN_BITS-1:0]       in_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [N_NEURONS*OUT_BITS-1:0] out_data,
    output logic [NW-1:0]                 conn_neuron,
    input  logic [FAN_IN*IW-1:0]          conn_sel,
    output logic                          lut_en,
    output logic [NW-1:0]                 lut_neuron,
    output logic [FAN_IN*IN_BITS-1:0]     lut_addr,
    input  logic [OUT_BITS-1:0]           lut_data,
    output logic                          busy
);

    state_t                          r_state;
    logic [N_IN*IN_BITS-1:0]         r_vec;
    logic [NW-1:0]                   r_k;
    logic                            r_lut_en_p1;
    logic [NW-1:0]                   r_lut_neuron_p1;
    logic [FAN_IN*IN_BITS-1:0]       r_lut_addr_p1;
    logic [N_NEURONS*OUT_BITS-1:0]   r_out;

    logic [IN_BITS-1:0]              w_feat [FAN_IN];
    logic [FAN_IN*IN_BITS-1:0]       w_addr;
    logic                            w_tag_vld;
    logic [NW-1:0]                   w_tag_idx;
    logic                            w_last_issue;
    logic                            w_last_tag;

    // Gather stage: ROM selects pick features; out-of-range selects fall back to feature 0.
    always_comb begin
        w_addr = '0;
        for (int k = 0; k < FAN_IN; k++) begin
            w_feat[k] = r_vec[IN_BITS-1:0];
            for (int f = 1; f < N_IN; f++) begin
                if (conn_sel[k*IW +: IW] == IW'(f)) begin
                    w_feat[k] = r_vec[f*IN_BITS +: IN_BITS];
                end
            end
            w_addr[addr_lsb(k, FAN_IN, IN_BITS) +: IN_BITS] = w_feat[k];
        end
    end

    assign w_last_issue = (r_k == NW'(N_NEURONS - 1));
    assign w_last_tag   = w_tag_vld && (w_tag_idx == NW'(N_NEURONS - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state         <= ST_IDLE;
            r_vec           <= '0;
            r_k             <= '0;
            r_lut_en_p1     <= 1'b0;
            r_lut_neuron_p1 <= '0;
            r_lut_addr_p1   <= '0;
        end else begin
            r_lut_en_p1 <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_vec   <= in_data;
                        r_k     <= '0;
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    r_lut_en_p1     <= 1'b1;
                    r_lut_neuron_p1 <= r_k;
                    r_lut_addr_p1   <= w_addr;
                    if (w_last_issue) begin
                        r_k     <= '0;
                        r_state <= ST_DRAIN;
                    end else begin
                        r_k <= r_k + 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (w_last_tag) begin
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Issue-to-result stage: the tag emerges exactly when lut_data belongs to it.
    lut_tag_pipe #(
        .LUT_LAT (LUT_LAT),
        .NW      (NW)
    ) u_tag_pipe (
        .i_clk (clk),
        .i_rst (rst),
        .i_vld (r_lut_en_p1),
        .i_idx (r_lut_neuron_p1),
        .o_vld (w_tag_vld),
        .o_idx (w_tag_idx)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out <= '0;
        end else if (r_state == ST_IDLE && in_valid) begin
            r_out <= '0;
        end else if (w_tag_vld) begin
            for (int n = 0; n < N_NEURONS; n++) begin
                if (w_tag_idx == NW'(n)) begin
                    r_out[n*OUT_BITS +: OUT_BITS] <= lut_data;
                end
            end
        end
    end

    assign in_ready    = (r_state == ST_IDLE);
    assign out_valid   = (r_state == ST_DONE);
    assign busy        = (r_state != ST_IDLE);
    assign out_data    = r_out;
    assign conn_neuron = r_k;
    assign lut_en      = r_lut_en_p1;
    assign lut_neuron  = r_lut_neuron_p1;
    assign lut_addr    = r_lut_addr_p1;

endmodule

// File: tb/tb_lut_layer_scheduler.sv
// Directed/random bench: LUT_LAT=1 and LUT_LAT=3 instances run in lockstep, plus an N_NEURONS=1 instance.
module tb_lut_layer_scheduler;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int rom [128][4];

    logic         rst, in_valid, out_ready, in_valid_c, out_ready_c, zero_lut;
    logic [127:0] in_data;

    logic         in_ready_a, out_valid_a, lut_en_a, busy_a;
    logic [255:0] out_data_a;
    logic [6:0]   conn_neuron_a, lut_neuron_a;
    logic [23:0]  conn_sel_a;
    logic [7:0]   lut_addr_a;
    logic [1:0]   lut_data_a;

    logic         in_ready_b, out_valid_b, lut_en_b, busy_b;
    logic [255:0] out_data_b;
    logic [6:0]   conn_neuron_b, lut_neuron_b;
    logic [23:0]  conn_sel_b;
    logic [7:0]   lut_addr_b;
    logic [1:0]   lut_data_b;

    logic         in_ready_c, out_valid_c, lut_en_c, busy_c;
    logic [1:0]   out_data_c;
    logic [0:0]   conn_neuron_c, lut_neuron_c;
    logic [23:0]  conn_sel_c;
    logic [7:0]   lut_addr_c;
    logic [1:0]   lut_data_c;

    lut_layer_scheduler #(.LUT_LAT(1)) u_dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a), .in_data(in_data),
        .out_valid(out_valid_a), .out_ready(out_ready), .out_data(out_data_a),
        .conn_neuron(conn_neuron_a), .conn_sel(conn_sel_a), .lut_en(lut_en_a),
        .lut_neuron(lut_neuron_a), .lut_addr(lut_addr_a), .lut_data(lut_data_a), .busy(busy_a));

    lut_layer_scheduler #(.LUT_LAT(3)) u_dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b), .in_data(in_data),
        .out_valid(out_valid_b), .out_ready(out_ready), .out_data(out_data_b),
        .conn_neuron(conn_neuron_b), .conn_sel(conn_sel_b), .lut_en(lut_en_b),
        .lut_neuron(lut_neuron_b), .lut_addr(lut_addr_b), .lut_data(lut_data_b), .busy(busy_b));

    lut_layer_scheduler #(.N_NEURONS(1), .LUT_LAT(1)) u_dut_c (
        .clk(clk), .rst(rst), .in_valid(in_valid_c), .in_ready(in_ready_c), .in_data(in_data),
        .out_valid(out_valid_c), .out_ready(out_ready_c), .out_data(out_data_c),
        .conn_neuron(conn_neuron_c), .conn_sel(conn_sel_c), .lut_en(lut_en_c),
        .lut_neuron(lut_neuron_c), .lut_addr(lut_addr_c), .lut_data(lut_data_c), .busy(busy_c));

    // Connectivity ROM: combinational lookup of the bench's table.
    always_comb begin
        conn_sel_a = '0;
        conn_sel_b = '0;
        conn_sel_c = '0;
        for (int k = 0; k < 4; k++) begin
            conn_sel_a[k*6 +: 6] = 6'(rom[conn_neuron_a][k]);
            conn_sel_b[k*6 +: 6] = 6'(rom[conn_neuron_b][k]);
            conn_sel_c[k*6 +: 6] = 6'(rom[conn_neuron_c][k]);
        end
    end

    // Echo LUT models with the matching fixed read latency.
    logic [1:0] pipe_a, pipe_c;
    logic [1:0] pipe_b [3];
    always @(posedge clk) begin
        pipe_a    <= lut_addr_a[1:0];
        pipe_b[0] <= lut_addr_b[1:0];
        pipe_b[1] <= pipe_b[0];
        pipe_b[2] <= pipe_b[1];
        pipe_c    <= lut_addr_c[1:0];
    end
    assign lut_data_a = zero_lut ? 2'b00 : pipe_a;
    assign lut_data_b = zero_lut ? 2'b00 : pipe_b[2];
    assign lut_data_c = zero_lut ? 2'b00 : pipe_c;

    function automatic logic [1:0] feat(input logic [127:0] v, input int f);
        logic [127:0] s;
        s = v >> (2 * f);
        return s[1:0];
    endfunction

    function automatic logic [7:0] exp_addr(input logic [127:0] v, input int n);
        int a;
        a = 0;
        for (int k = 0; k < 4; k++) a = (a << 2) | int'(feat(v, rom[n][k]));
        return 8'(a);
    endfunction

    function automatic logic [255:0] exp_out(input logic [127:0] v);
        logic [255:0] r;
        r = '0;
        for (int n = 0; n < 128; n++) r = r | (256'(feat(v, rom[n][3])) << (2 * n));
        return r;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_rst_ab();
        check("a_rst_in_ready", 256'(in_ready_a), 256'(1));
        check("a_rst_out_valid", 256'(out_valid_a), 256'(0));
        check("a_rst_out_data", out_data_a, 256'(0));
        check("a_rst_lut_en", 256'(lut_en_a), 256'(0));
        check("a_rst_lut_neuron", 256'(lut_neuron_a), 256'(0));
        check("a_rst_lut_addr", 256'(lut_addr_a), 256'(0));
        check("a_rst_conn_neuron", 256'(conn_neuron_a), 256'(0));
        check("a_rst_busy", 256'(busy_a), 256'(0));
        check("b_rst_out_valid", 256'(out_valid_b), 256'(0));
        check("b_rst_out_data", out_data_b, 256'(0));
        check("b_rst_lut_en", 256'(lut_en_b), 256'(0));
        check("b_rst_busy", 256'(busy_b), 256'(0));
    endtask

    // Called mid-cycle with both A and B idle; returns mid-cycle in C0+1.
    task automatic start(input logic [127:0] v);
        check("a_in_ready", 256'(in_ready_a), 256'(1));
        check("b_in_ready", 256'(in_ready_b), 256'(1));
        in_valid = 1'b1;
        in_data  = v;
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = rnd128();
    endtask

    // Follows both instances from C0+1 until each has raised out_valid.
    task automatic collect(input logic [127:0] v, input bit pack_chk);
        int na, nb, ta, tbt, t;
        logic [255:0] eo;
        na = 0; nb = 0; ta = 0; tbt = 0; t = 1;
        eo = zero_lut ? 256'(0) : exp_out(v);
        check("a_busy_run", 256'(busy_a), 256'(1));
        while ((ta == 0 || tbt == 0) && t < 300) begin
            if (lut_en_a) begin
                check("a_lut_neuron", 256'(lut_neuron_a), 256'(na));
                check("a_lut_addr", 256'(lut_addr_a), 256'(exp_addr(v, na)));
                check("a_issue_cycle", 256'(t), 256'(na + 2));
                if (pack_chk && na == 5) check("a_addr_pack", 256'(lut_addr_a), 256'(8'b01101100));
                na++;
            end
            if (lut_en_b) begin
                check("b_lut_neuron", 256'(lut_neuron_b), 256'(nb));
                check("b_lut_addr", 256'(lut_addr_b), 256'(exp_addr(v, nb)));
                nb++;
            end
            if (out_valid_a && ta == 0) begin
                ta = t;
                check("a_out_data", out_data_a, eo);
            end
            if (out_valid_b && tbt == 0) begin
                tbt = t;
                check("b_out_data", out_data_b, eo);
            end
            if (ta == 0 || tbt == 0) begin
                @(negedge clk);
                t++;
            end
        end
        check("a_latency", 256'(ta), 256'(131));
        check("b_latency", 256'(tbt), 256'(133));
        check("a_issues", 256'(na), 256'(128));
        check("b_issues", 256'(nb), 256'(128));
    endtask

    initial begin
        logic [127:0] v, v2;
        rst = 1'b1; in_valid = 1'b0; in_valid_c = 1'b0;
        out_ready = 1'b1; out_ready_c = 1'b1; zero_lut = 1'b1; in_data = '0;
        for (int n = 0; n < 128; n++)
            for (int k = 0; k < 4; k++) rom[n][k] = int'($urandom_range(0, 63));
        for (int k = 0; k < 4; k++) rom[5][k] = k;

        repeat (2) @(negedge clk);
        chk_rst_ab();
        rst = 1'b0;
        @(negedge clk);

        // All-zero LUT: timing, issue order and a cleared result vector.
        v = rnd128();
        start(v);
        collect(v, 1'b0);
        @(negedge clk);
        check("b_idle_out_valid", 256'(out_valid_b), 256'(0));

        // Address packing with a known feature pattern, echo LUT from here on.
        zero_lut = 1'b0;
        v = rnd128();
        v[7:0] = 8'h39;
        start(v);
        collect(v, 1'b1);
        @(negedge clk);

        repeat (2) begin
            v = rnd128();
            start(v);
            collect(v, 1'b0);
            @(negedge clk);
        end

        // Back-pressure with a second vector waiting on in_valid.
        out_ready = 1'b0;
        v = rnd128();
        start(v);
        collect(v, 1'b0);
        v2 = rnd128();
        in_valid = 1'b1;
        in_data  = v2;
        for (int i = 0; i < 20; i++) begin
            check("a_hold_valid", 256'(out_valid_a), 256'(1));
            check("b_hold_valid", 256'(out_valid_b), 256'(1));
            check("a_hold_in_ready", 256'(in_ready_a), 256'(0));
            check("a_hold_data", out_data_a, exp_out(v));
            check("b_hold_data", out_data_b, exp_out(v));
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("a_after_ready_in_ready", 256'(in_ready_a), 256'(1));
        check("a_after_ready_out_valid", 256'(out_valid_a), 256'(0));
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = rnd128();
        collect(v2, 1'b0);
        @(negedge clk);

        // Reset in the middle of RUN; late LUT returns must not land anywhere.
        v = rnd128();
        start(v);
        repeat (49) @(negedge clk);
        rst = 1'b1;
        #1;
        chk_rst_ab();
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("a_post_rst_data", out_data_a, 256'(0));
            check("b_post_rst_data", out_data_b, 256'(0));
            @(negedge clk);
        end
        v = rnd128();
        start(v);
        collect(v, 1'b0);
        @(negedge clk);

        // Single-neuron layer.
        v = rnd128();
        in_data = v;
        check("c_in_ready", 256'(in_ready_c), 256'(1));
        in_valid_c = 1'b1;
        @(negedge clk);
        in_valid_c = 1'b0;
        for (int t = 1; t <= 5; t++) begin
            check("c_busy", 256'(busy_c), 256'(t <= 4));
            check("c_out_valid", 256'(out_valid_c), 256'(t == 4));
            check("c_lut_en", 256'(lut_en_c), 256'(t == 2));
            if (t == 2) check("c_lut_addr", 256'(lut_addr_c), 256'(exp_addr(v, 0)));
            if (t == 4) check("c_out_data", 256'(out_data_c), 256'(feat(v, rom[0][3])));
            @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
